issue_scoreboard: RTL and testbench

//  Controls issue from decode to execute. Tracks pending writes to x1..x31 in a busy table and stalls RAW/WAW hazards.

---
 rtl/issue_scoreboard_pkg.sv | 30 +++
 rtl/sb_clear_mask.sv | 28 ++
 rtl/issue_scoreboard.sv | 112 +++++++++++
 tb/tb_issue_scoreboard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the decode-to-execute issue scoreboard: decoded instruction
// layout, issue FSM states and a register one-hot helper.
package issue_scoreboard_pkg;

  localparam int NUM_ARCH_REGS = 32;

  typedef enum logic [1:0] {RUN, CSR_DRAIN, CSR_WAIT, FLUSH} issue_state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic        rd_v;
    logic [4:0]  rd;
    logic        rs1_v;
    logic [4:0]  rs1;
    logic        rs2_v;
    logic [4:0]  rs2;
    logic        is_csr;
    logic [31:0] imm;
  } instr_dec_t;

  // x0 is hardwired to zero, so it can never appear in a busy or clear mask
  function automatic logic [NUM_ARCH_REGS-1:0] reg_onehot(input logic [4:0] idx);
    logic [NUM_ARCH_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    m[0]   = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/sb_clear_mask.sv
// Folds the commit ports into a mask of registers whose pending write retired
// this cycle, plus the number of instructions retired.
module sb_clear_mask
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_CMT = 2
) (
  input  logic [NUM_CMT-1:0]             cmt_valid,
  input  logic [NUM_CMT-1:0]             cmt_rd_v,
  input  logic [NUM_CMT*5-1:0]           cmt_rd,
  output logic [NUM_ARCH_REGS-1:0]       clr_mask,
  output logic [$clog2(NUM_CMT+1)-1:0]   cmt_count
);

  localparam int CW = $clog2(NUM_CMT + 1);

  always_comb begin
    clr_mask  = '0;
    cmt_count = '0;
    for (int k = 0; k < NUM_CMT; k++) begin
      if (cmt_valid[k] && cmt_rd_v[k]) begin
        clr_mask = clr_mask | reg_onehot(cmt_rd[k*5 +: 5]);
      end
      cmt_count = cmt_count + CW'(cmt_valid[k]);
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue control between decode and execute: busy-table hazard stalls, CSR
// serialisation, in-flight bound, flush handling and a one-entry output register.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int NUM_CMT      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dec_valid_i,
  input  instr_dec_t                        dec_instr_i,
  output logic                              dec_ready_o,
  output logic                              iss_valid_o,
  output instr_dec_t                        iss_instr_o,
  input  logic                              iss_ready_i,
  input  logic [NUM_CMT-1:0]                cmt_valid_i,
  input  logic [NUM_CMT-1:0]                cmt_rd_v_i,
  input  logic [NUM_CMT*5-1:0]              cmt_rd_i,
  input  logic                              flush_i,
  output logic [NUM_ARCH_REGS-1:0]          busy_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o
);

  localparam int              IW      = $clog2(MAX_INFLIGHT + 1);
  localparam int              CW      = $clog2(NUM_CMT + 1);
  localparam logic [IW-1:0]   MAX_CNT = IW'(MAX_INFLIGHT);

  issue_state_t             state;
  logic [NUM_ARCH_REGS-1:0] busy;
  logic [IW-1:0]            inflight;

  logic [NUM_ARCH_REGS-1:0] clr_mask;
  logic [CW-1:0]            cmt_count;
  logic [NUM_ARCH_REGS-1:0] busy_eff;
  logic [NUM_ARCH_REGS-1:0] set_mask;
  logic [IW-1:0]            inflight_base;
  logic                     hazard;
  logic                     out_free;
  logic                     accept;

  sb_clear_mask #(.NUM_CMT(NUM_CMT)) u_clear_mask (
    .cmt_valid (cmt_valid_i),
    .cmt_rd_v  (cmt_rd_v_i),
    .cmt_rd    (cmt_rd_i),
    .clr_mask  (clr_mask),
    .cmt_count (cmt_count)
  );

  // Registers retiring this cycle are already treated as free for hazard checks
  assign busy_eff      = busy & ~clr_mask;
  assign inflight_base = inflight - IW'(cmt_count);
  assign out_free      = !iss_valid_o || iss_ready_i;

  assign hazard = (dec_instr_i.rs1_v && busy_eff[dec_instr_i.rs1])
               || (dec_instr_i.rs2_v && busy_eff[dec_instr_i.rs2])
               || (dec_instr_i.rd_v  && busy_eff[dec_instr_i.rd]);

  always_comb begin
    dec_ready_o = 1'b0;
    if (!rst && !flush_i) begin
      case (state)
        RUN:       dec_ready_o = !hazard && !dec_instr_i.is_csr
                                 && (inflight_base < MAX_CNT) && out_free;
        CSR_DRAIN: dec_ready_o = (inflight_base == '0) && !iss_valid_o && !hazard;
        default:   dec_ready_o = 1'b0;
      endcase
    end
  end

  assign accept   = dec_valid_i && dec_ready_o;
  assign set_mask = (accept && dec_instr_i.rd_v) ? reg_onehot(dec_instr_i.rd) : '0;

  // Set is OR-ed after the clear so a new writer keeps its register busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      busy        <= '0;
      inflight    <= '0;
      iss_valid_o <= 1'b0;
      iss_instr_o <= '0;
    end else if (flush_i) begin
      state       <= FLUSH;
      busy        <= '0;
      inflight    <= '0;
      iss_valid_o <= 1'b0;
    end else begin
      busy     <= busy_eff | set_mask;
      inflight <= inflight_base + IW'(accept);
      if (accept) begin
        iss_valid_o <= 1'b1;
        iss_instr_o <= dec_instr_i;
      end else if (iss_ready_i) begin
        iss_valid_o <= 1'b0;
      end
      case (state)
        RUN:       if (dec_valid_i && dec_instr_i.is_csr) state <= CSR_DRAIN;
        CSR_DRAIN: if (accept) state <= CSR_WAIT;
        CSR_WAIT:  if (inflight_base == '0) state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  assign busy_o     = busy;
  assign inflight_o = inflight;

  // Retiring more instructions than are in flight means the commit side is broken
  commit_underflow: assert property (@(posedge clk) disable iff (rst)
    int'(cmt_count) <= int'(inflight));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed, table-driven bench for issue_scoreboard: hazards, full window,
// CSR serialisation, flush, backpressure and mid-operation reset.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  instr_dec_t  dec_instr;
  logic        dec_ready;
  logic        iss_valid;
  instr_dec_t  iss_instr;
  logic        iss_ready;
  logic [1:0]  cmt_valid;
  logic [1:0]  cmt_rd_v;
  logic [9:0]  cmt_rd;
  logic        flush;
  logic [31:0] busy;
  logic [3:0]  inflight;

  issue_scoreboard #(.MAX_INFLIGHT(8), .NUM_CMT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid_i (dec_valid),
    .dec_instr_i (dec_instr),
    .dec_ready_o (dec_ready),
    .iss_valid_o (iss_valid),
    .iss_instr_o (iss_instr),
    .iss_ready_i (iss_ready),
    .cmt_valid_i (cmt_valid),
    .cmt_rd_v_i  (cmt_rd_v),
    .cmt_rd_i    (cmt_rd),
    .flush_i     (flush),
    .busy_o      (busy),
    .inflight_o  (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    instr_dec_t  instr;
    logic        irdy;
    logic [1:0]  cv;
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic        fl;
    logic        rs;
    logic        e_rdy;
    logic        e_iv;
    logic [4:0]  e_rd;
    logic [31:0] e_busy;
    logic [3:0]  e_inf;
  } vec_t;

  int   compared   = 0;
  int   mismatched = 0;
  int   step       = 0;
  vec_t tbl[$];

  function automatic instr_dec_t ins(input logic [4:0] rd, input logic rd_v,
                                     input logic [4:0] rs1, input logic rs1_v,
                                     input logic [4:0] rs2, input logic rs2_v,
                                     input logic csr);
    instr_dec_t i;
    i        = '0;
    i.rd     = rd;
    i.rd_v   = rd_v;
    i.rs1    = rs1;
    i.rs1_v  = rs1_v;
    i.rs2    = rs2;
    i.rs2_v  = rs2_v;
    i.is_csr = csr;
    return i;
  endfunction

  function automatic vec_t mk(input logic dv, input instr_dec_t instr, input logic irdy,
                              input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                              input logic fl, input logic rs, input logic e_rdy,
                              input logic e_iv, input logic [4:0] e_rd,
                              input logic [31:0] e_busy, input logic [3:0] e_inf);
    vec_t v;
    v.dv = dv; v.instr = instr; v.irdy = irdy; v.cv = cv; v.c0 = c0; v.c1 = c1;
    v.fl = fl; v.rs = rs; v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_rd = e_rd;
    v.e_busy = e_busy; v.e_inf = e_inf;
    return v;
  endfunction

  task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, step, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rs;
    dec_valid = v.dv;
    dec_instr = v.instr;
    iss_ready = v.irdy;
    cmt_valid = v.cv;
    cmt_rd_v  = v.cv;
    cmt_rd    = {v.c1, v.c0};
    flush     = v.fl;
  endtask

  // dec_ready is combinational, so it is sampled before the edge; state after it
  task automatic checkOutput(input vec_t v);
    #1;
    compareField("dec_ready", 64'(dec_ready), 64'(v.e_rdy));
    @(posedge clk);
    #1;
    compareField("iss_valid", 64'(iss_valid), 64'(v.e_iv));
    compareField("busy", 64'(busy), 64'(v.e_busy));
    compareField("inflight", 64'(inflight), 64'(v.e_inf));
    if (v.e_iv) compareField("iss_rd", 64'(iss_instr.rd), 64'(v.e_rd));
    if (v.rs)   compareField("iss_instr_reset", 64'(iss_instr), 64'd0);
    step++;
  endtask

  initial begin
    instr_dec_t nop;
    instr_dec_t csr;
    instr_dec_t x;
    nop = ins(0, 0, 0, 0, 0, 0, 0);
    csr = ins(0, 0, 0, 0, 0, 0, 1);

    // reset, then RAW stall released by a same-cycle commit
    tbl.push_back(mk(1, ins(5,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(5,1,1,1,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 5, 32'h20, 1));
    tbl.push_back(mk(1, ins(6,1,5,1,1,1,0), 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1));
    tbl.push_back(mk(1, ins(6,1,5,1,1,1,0), 1, 2'b01, 5, 0, 0, 0, 1, 1, 6, 32'h40, 1));
    // WAW with set winning over clear, then WAW stall and dual commit
    tbl.push_back(mk(1, ins(7,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 7, 32'hC0, 2));
    tbl.push_back(mk(1, ins(7,1,0,0,0,0,0), 1, 2'b01, 7, 0, 0, 0, 1, 1, 7, 32'hC0, 2));
    tbl.push_back(mk(1, ins(6,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hC0, 2));
    tbl.push_back(mk(0, nop,                1, 2'b11, 6, 7, 0, 0, 1, 0, 0, 32'h0, 0));
    // fill the window; x0 as rd or source never becomes busy
    tbl.push_back(mk(1, ins(0,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 32'h0, 1));
    tbl.push_back(mk(1, ins(0,0,0,1,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 32'h0, 2));
    for (int k = 3; k <= 8; k++)
      tbl.push_back(mk(1, nop, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 32'h0, 4'(k)));
    tbl.push_back(mk(1, nop, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8));
    tbl.push_back(mk(1, nop, 1, 2'b01, 0, 0, 0, 0, 1, 1, 0, 32'h0, 8));
    tbl.push_back(mk(0, nop, 1, 2'b11, 0, 0, 0, 0, 1, 0, 0, 32'h0, 6));
    tbl.push_back(mk(0, nop, 1, 2'b11, 0, 0, 0, 0, 1, 0, 0, 32'h0, 4));
    tbl.push_back(mk(0, nop, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 32'h0, 3));
    // CSR: drain three, issue, hold younger instr until the CSR commits
    tbl.push_back(mk(1, csr, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 3));
    tbl.push_back(mk(1, csr, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2));
    tbl.push_back(mk(1, csr, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
    tbl.push_back(mk(1, csr, 1, 2'b01, 0, 0, 0, 0, 1, 1, 0, 32'h0, 1));
    tbl.push_back(mk(1, nop, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
    tbl.push_back(mk(1, nop, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(8,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 8, 32'h100, 1));
    // flush with busy=0xA0, two in flight, output register full
    tbl.push_back(mk(1, ins(5,1,0,0,0,0,0), 1, 2'b01, 8, 0, 0, 0, 1, 1, 5, 32'h20, 1));
    tbl.push_back(mk(1, ins(7,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 7, 32'hA0, 2));
    tbl.push_back(mk(1, ins(9,1,0,0,0,0,0), 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(9,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(9,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 9, 32'h200, 1));
    // backpressure: output held for five cycles
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, ins(10,1,0,0,0,0,0), 0, 2'b00, 0, 0, 0, 0, 0, 1, 9, 32'h200, 1));
    tbl.push_back(mk(1, ins(10,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 10, 32'h600, 2));
    // reset while waiting for a CSR to commit
    tbl.push_back(mk(1, ins(11,1,0,0,0,0,1), 1, 2'b11, 9, 10, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(11,1,0,0,0,0,1), 1, 2'b00, 0, 0, 0, 0, 1, 1, 11, 32'h800, 1));
    tbl.push_back(mk(1, ins(12,1,0,0,0,0,0), 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(12,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 12, 32'h1000, 1));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // whole instruction word must stay frozen while execute stalls
    x        = ins(13, 1, 0, 0, 0, 0, 0);
    x.opcode = 7'h33;
    x.imm    = 32'hDEAD_BEEF;
    applyStimulus(mk(1, x, 1, 2'b00, 0, 0, 0, 0, 1, 1, 13, 32'h3000, 2));
    checkOutput(mk(1, x, 1, 2'b00, 0, 0, 0, 0, 1, 1, 13, 32'h3000, 2));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(mk(0, nop, 0, 2'b00, 0, 0, 0, 0, 0, 1, 13, 32'h3000, 2));
      checkOutput(mk(0, nop, 0, 2'b00, 0, 0, 0, 0, 0, 1, 13, 32'h3000, 2));
      compareField("iss_instr_hold", 64'(iss_instr), 64'(x));
    end
    applyStimulus(mk(0, nop, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 32'h3000, 2));
    checkOutput(mk(0, nop, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 32'h3000, 2));

    // flush out of CSR_DRAIN, then a clean CSR round trip
    tbl.delete();
    tbl.push_back(mk(1, csr, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 2));
    tbl.push_back(mk(1, csr, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, csr, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, csr, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, csr, 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 32'h0, 1));
    tbl.push_back(mk(1, ins(14,1,0,0,0,0,0), 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, ins(14,1,0,0,0,0,0), 1, 2'b00, 0, 0, 0, 0, 1, 1, 14, 32'h4000, 1));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
